// File: rtl/device_helper_pkg.sv
// device_helper_pkg: response payload type, configuration checks and the
// call into the behavioural device model shared by every bridge instance.
package device_helper_pkg;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_ID_W   = 16;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  wen;
        logic [MAX_ID_W-1:0]   id;
    } resp_t;

    function automatic bit cfg_ok(input int addr_w, input int data_w, input int depth, input int latency);
        return (data_w == 32 || data_w == 64) && addr_w >= 1 && addr_w <= 64 && depth >= 1 && latency >= 1;
    endfunction

    bit [63:0]   dev_mem [16];
    int unsigned dev_calls;
    bit          dev_last_wen;
    logic [63:0] dev_last_addr;
    logic [63:0] dev_last_wdata;
    logic [7:0]  dev_last_mask;

    // Device model: a 16-word register file indexed by addr[5:2], byte-masked writes.
    function automatic void device_helper_wide(input bit wen, input longint addr, input longint wdata,
                                               input byte mask, output longint rdata);
        bit [63:0] w;
        w = dev_mem[addr[5:2]];
        dev_calls++;
        dev_last_wen   = wen;
        dev_last_addr  = addr;
        dev_last_wdata = wdata;
        dev_last_mask  = mask;
        rdata = longint'(w);
        if (wen) begin
            for (int b = 0; b < 8; b++)
                if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
            dev_mem[addr[5:2]] = w;
        end
    endfunction

    // One device transaction; write responses carry no data.
    function automatic logic [63:0] device_xfer(input logic wen, input logic [63:0] addr,
                                                input logic [63:0] wdata, input logic [7:0] mask);
        longint rdata;
        device_helper_wide(wen, addr, wdata, mask, rdata);
        return wen ? 64'd0 : 64'(rdata);
    endfunction
endpackage

// File: rtl/device_resp_fifo.sv
// device_resp_fifo: DEPTH-entry synchronous FIFO of response payloads,
// async reset of pointers and count, no bypass.
module device_resp_fifo
    import device_helper_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  resp_t push_data,
    input  logic  pop,
    output logic  empty,
    output resp_t head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    resp_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_d  = push ? inc(wr_q) : wr_q;
        rd_d  = pop ? inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        empty = cnt_q == '0;
        head  = mem_q[rd_q];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/device_helper_bridge.sv
// device_helper_bridge: valid/ready MMIO bridge that calls the device model once
// per accepted request and returns results in order after a fixed latency.
module device_helper_bridge
    import device_helper_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wen,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_wmask,
    input  logic [ID_W-1:0]            req_id,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_wen,
    output logic [ID_W-1:0]            resp_id,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);
    localparam int CW = $clog2(DEPTH + 1);

    if (!cfg_ok(ADDR_W, DATA_W, DEPTH, LATENCY) || ID_W > MAX_ID_W) begin : g_bad_cfg
        $error("device_helper_bridge: unsupported parameter set");
    end

    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [LATENCY-1:0] pv_q;
    resp_t              pipe_q [LATENCY];
    resp_t              head;
    logic               accept, pop, fifo_empty, unused_bits;

    // Ready depends only on registered occupancy, so a same-cycle pop cannot raise it.
    always_comb begin
        req_ready     = !reset && (outstanding_q != CW'(DEPTH));
        accept        = req_valid && req_ready;
        resp_valid    = !fifo_empty;
        pop           = resp_valid && resp_ready;
        outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
        outstanding   = outstanding_q;
        resp_rdata    = resp_valid ? head.rdata[DATA_W-1:0] : '0;
        resp_wen      = resp_valid && head.wen;
        resp_id       = resp_valid ? head.id[ID_W-1:0] : '0;
        unused_bits   = ^head;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) outstanding_q <= '0;
        else outstanding_q <= outstanding_d;

    // The device call happens at the accepting edge and feeds stage 0 directly.
    always_ff @(posedge clk or posedge reset)
        if (reset) pv_q <= '0;
        else begin
            pv_q[0] <= accept;
            if (accept) begin
                pipe_q[0].rdata <= device_xfer(req_wen, 64'(req_addr), 64'(req_wdata), 8'(req_wmask));
                pipe_q[0].wen   <= req_wen;
                pipe_q[0].id    <= MAX_ID_W'(req_id);
            end
            for (int i = LATENCY - 1; i > 0; i--) begin
                pv_q[i]   <= pv_q[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
        end

    device_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pv_q[LATENCY-1]),
        .push_data (pipe_q[LATENCY-1]),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head)
    );
endmodule
